microwave_timer_ctrl: RTL and testbench

- Controller that sequences the microwave countdown datapath: one minutes digit plus two seconds digits, built from BCD down-counters with `loadn`, `EN`, `data` inputs and a combined `zero` flag.
- Captures keypad digits into a 3-digit entry buffer and loads them into the counters.
- Generates the 1 Hz count-enable pulses, handles start, stop and door-open, and drives the magnetron and end-of-cook alarm.
- Sits between the keypad/button front end and the timer counters.

---
 rtl/microwave_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 21 ++
 rtl/microwave_timer_ctrl.sv | 72 +++++++
 tb/tb_microwave_timer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding, digit limits and entry check for the microwave timer controller
package microwave_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    function automatic logic entry_ok(input logic [3:0] min, input logic [3:0] tens, input logic [3:0] ones);
        return ({min, tens, ones} != 12'd0) && (tens <= SEC_TENS_MAX);
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pauses while run=0 and emits tick on its last count
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic clear,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (clear || restart)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
    assign tick = run && (cnt == LAST);
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, load/cook/pause/done sequencing and 1 Hz count enables for the BCD timer
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       timer_zero,
    output logic       load_n,
    output logic       count_en,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_ones,
    output logic       magnetron_on,
    output logic       done_alarm,
    output logic [2:0] state
);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    state_t st, nxt;
    logic run, tick, alarm_last, key_ok, clr_buf, leave_done;
    logic [AW-1:0] alarm_cnt;
    // The prescaler only advances in cycles where the timer really progresses, so a pause holds its phase
    assign run = (st == COOKING && !stop && door_closed && !timer_zero) || (st == DONE && !stop);
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .clear  (clear),
        .run    (run),
        .restart(st == LOAD),
        .tick   (tick)
    );
    assign alarm_last = alarm_cnt == AW'(ALARM_TICKS - 1);
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = (!stop && door_closed && start && entry_ok(data_min, data_sec_tens, data_sec_ones)) ? LOAD : IDLE;
            LOAD:    nxt = COOKING;
            COOKING: nxt = (stop || !door_closed) ? PAUSED : timer_zero ? DONE : COOKING;
            PAUSED:  nxt = stop ? IDLE : (door_closed && start) ? COOKING : PAUSED;
            DONE:    nxt = (stop || (tick && alarm_last)) ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    assign key_ok     = st == IDLE && key_valid && key_digit <= BCD_MAX;
    assign leave_done = st == DONE && nxt != DONE;
    assign clr_buf    = (st == PAUSED || st == DONE) && nxt == IDLE;
    always_ff @(posedge clk) begin
        if (clear) begin
            st <= IDLE;
            alarm_cnt <= '0;
            {data_min, data_sec_tens, data_sec_ones} <= '0;
        end else begin
            st <= nxt;
            alarm_cnt <= leave_done ? '0 : (st == DONE && tick) ? alarm_cnt + 1'b1 : alarm_cnt;
            if (clr_buf)
                {data_min, data_sec_tens, data_sec_ones} <= '0;
            else if (key_ok)
                {data_min, data_sec_tens, data_sec_ones} <= {data_sec_tens, data_sec_ones, key_digit};
        end
    end
    assign load_n       = st != LOAD;
    assign count_en     = st == COOKING && tick;
    assign magnetron_on = st == COOKING;
    assign done_alarm   = st == DONE;
    assign state        = st;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: directed and random stimulus checked each cycle against a behavioural controller model
module tb_microwave_timer_ctrl;
    import microwave_pkg::*;
    localparam int TD = 4;
    localparam int AT = 2;
    logic clk = 1'b0;
    logic clear, start, stop, door_closed, key_valid, timer_zero;
    logic [3:0] key_digit;
    logic load_n, count_en, magnetron_on, done_alarm;
    logic [3:0] data_min, data_sec_tens, data_sec_ones;
    logic [2:0] state;
    int total = 0;
    int bad = 0;
    int t_secs = 0;
    int b[3];
    int pre, alarms, pulses, done_cyc, p0;
    state_t m_st;

    microwave_timer_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .door_closed(door_closed),
        .key_valid(key_valid), .key_digit(key_digit), .timer_zero(timer_zero),
        .load_n(load_n), .count_en(count_en), .data_min(data_min), .data_sec_tens(data_sec_tens),
        .data_sec_ones(data_sec_ones), .magnetron_on(magnetron_on), .done_alarm(done_alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = IDLE;
        b = '{0, 0, 0};
        pre = 0;
        alarms = 0;
    endtask

    // One clock: compare at the falling edge, then advance the timer environment and the model at the rising edge
    task automatic cyc();
        logic adv, fire, go, ln, ce;
        int ld;
        @(negedge clk);
        adv  = (m_st == COOKING && !stop && door_closed && !timer_zero) || (m_st == DONE && !stop);
        fire = adv && pre == TD - 1;
        chk("state", state, m_st);
        chk("load_n", load_n, m_st != LOAD);
        chk("count_en", count_en, m_st == COOKING && fire);
        chk("magnetron_on", magnetron_on, m_st == COOKING);
        chk("done_alarm", done_alarm, m_st == DONE);
        chk("buf_min", data_min, b[0]);
        chk("buf_tens", data_sec_tens, b[1]);
        chk("buf_ones", data_sec_ones, b[2]);
        ln = load_n;
        ce = count_en;
        ld = data_min * 60 + data_sec_tens * 10 + data_sec_ones;
        if (m_st == DONE) done_cyc++;
        if (ce) pulses++;
        @(posedge clk);
        if (!ln) t_secs = ld;
        else if (ce && t_secs > 0) t_secs--;
        if (clear) model_reset();
        else begin
            go = !stop && door_closed && start && (b[0] + b[1] + b[2] != 0) && b[1] <= 5;
            case (m_st)
                IDLE: begin
                    if (key_valid && key_digit <= 9) begin
                        b[0] = b[1];
                        b[1] = b[2];
                        b[2] = int'(key_digit);
                    end
                    if (go) m_st = LOAD;
                end
                LOAD: begin
                    pre = 0;
                    m_st = COOKING;
                end
                COOKING: begin
                    if (stop || !door_closed) m_st = PAUSED;
                    else if (timer_zero) m_st = DONE;
                end
                PAUSED: begin
                    if (stop) begin
                        m_st = IDLE;
                        b = '{0, 0, 0};
                    end else if (door_closed && start) m_st = COOKING;
                end
                default: begin
                    if (fire) alarms++;
                    if (stop || alarms == AT) begin
                        m_st = IDLE;
                        b = '{0, 0, 0};
                        alarms = 0;
                    end
                end
            endcase
            if (adv) pre = (pre + 1) % TD;
        end
        #1 timer_zero = (t_secs == 0);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_until(input state_t s, input int lim, input string tag);
        int n = 0;
        while (m_st != s && n < lim) begin
            cyc();
            n++;
        end
        chk(tag, state, s);
    endtask

    initial begin
        {clear, start, stop, key_valid, key_digit} = '0;
        door_closed = 1'b1;
        timer_zero = 1'b1;
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        model_reset();
        cyc();
        key(4'd1); key(4'd3); key(4'd0);
        chk("buf_130", {data_min, data_sec_tens, data_sec_ones}, 12'h130);
        press_start();
        chk("load_low", load_n, 1'b0);
        cyc();
        pulses = 0;
        repeat (3) cyc();
        chk("first_pulse_not_early", pulses, 0);
        cyc();
        chk("first_pulse", pulses, 1);
        repeat (8) cyc();
        chk("pulse_period", pulses, 3);
        stop = 1'b1;
        cyc();
        cyc();
        stop = 1'b0;
        chk("stop_to_idle", state, IDLE);
        key(4'd7);
        pulses = 0;
        done_cyc = 0;
        press_start();
        run_until(IDLE, 200, "cook7_to_idle");
        chk("cook7_pulses", pulses, 7);
        chk("alarm_cycles", done_cyc, 8);
        chk("buf_cleared_done", {data_min, data_sec_tens, data_sec_ones}, 12'h000);
        key(4'd5);
        press_start();
        cyc();
        cyc();
        cyc();
        door_closed = 1'b0;
        cyc();
        cyc();
        chk("door_pause_mag", magnetron_on, 1'b0);
        cyc();
        door_closed = 1'b1;
        p0 = pulses;
        press_start();
        cyc();
        chk("resume_no_pulse", pulses, p0);
        cyc();
        chk("resume_pulse", pulses, p0 + 1);
        stop = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        {stop, start} = 2'b00;
        chk("stop_beats_start", state, IDLE);
        chk("stop_start_buf", {data_min, data_sec_tens, data_sec_ones}, 12'h000);
        key(4'd5);
        press_start();
        cyc();
        key(4'd8);
        chk("key_in_cook", {data_min, data_sec_tens, data_sec_ones}, 12'h005);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_cook_state", state, IDLE);
        chk("clear_cook_mag", magnetron_on, 1'b0);
        key(4'd9); key(4'd9);
        press_start();
        cyc();
        chk("reject_tens", state, IDLE);
        key(4'd12);
        chk("ignore_key12", {data_min, data_sec_tens, data_sec_ones}, 12'h099);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        press_start();
        cyc();
        chk("reject_zero", state, IDLE);
        key(4'd1);
        press_start();
        run_until(DONE, 50, "reach_done");
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_done_alarm", done_alarm, 1'b0);
        chk("clear_done_load", load_n, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            clear       = $urandom_range(0, 199) == 0;
            stop        = $urandom_range(0, 19) == 0;
            door_closed = $urandom_range(0, 9) != 0;
            start       = $urandom_range(0, 3) == 0;
            key_valid   = $urandom_range(0, 2) == 0;
            key_digit   = 4'($urandom_range(0, 15));
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
